// File: rtl/dma_buf_pkg.sv
// Shared helpers for DMA buffering: RAM read latency, prefetch depth
// and count width rules.
package dma_buf_pkg;

    localparam int PF_N = 4;

    function automatic int ram_rd_lat(input int do_reg);
        return (do_reg != 0) ? 2 : 1;
    endfunction

    function automatic int pf_depth(input int do_reg);
        return ram_rd_lat(do_reg) + 2;
    endfunction

    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fwft_prefetch_buf.sv
// Four-register FIFO holding words read from the RAM; presents the head
// word and grants read credit so in-flight reads always find a slot.
module fwft_prefetch_buf
    import dma_buf_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int PF_D   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              rd_rdy,
    input  logic [1:0]        infl,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              pop,
    output logic              credit_ok
);

    logic [DATA_W-1:0] buf_q [PF_N];
    logic [DATA_W-1:0] buf_d [PF_N];
    logic [1:0]        wr_q, wr_d;
    logic [1:0]        rd_q, rd_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic [3:0]        occ;

    always_comb begin
        buf_d = buf_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        pop   = vld_q && rd_rdy;
        if (cap_en) begin
            buf_d[wr_q] = cap_data;
            wr_d        = wr_q + 2'd1;
        end
        if (pop) begin
            rd_d = rd_q + 2'd1;
        end
        cnt_d = cnt_q + {2'b0, cap_en} - {2'b0, pop};
        vld_d = (cnt_d != 3'd0);
        // a slot freed by this cycle's pop may be reused by a new read
        occ       = {2'b0, infl} + {1'b0, cnt_q} - {3'b0, pop};
        credit_ok = (occ < 4'(PF_D));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PF_N; i++) begin
                buf_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    assign rd_vld  = vld_q;
    assign rd_data = buf_q[rd_q];

endmodule

// File: rtl/intel_sdpram.sv
// Simple dual-port RAM primitive: registered read, optional output
// register (DO_REG) adding a second cycle of read latency.
module intel_sdpram #(
    parameter int    ADDR_W    = 9,
    parameter int    DATA_W    = 64,
    parameter int    DO_REG    = 0,
    parameter string BRAM_TYPE = "M20K"
) (
    input  logic              clk_wr,
    input  logic              clk_rd,
    input  logic              reset,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic [DATA_W-1:0] data,
    input  logic              rden,
    input  logic [ADDR_W-1:0] rdaddress,
    output logic [DATA_W-1:0] q
);

    // MLAB output registers have no async clear; M20K ones do
    localparam bit RST_Q = (BRAM_TYPE != "MLAB");

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk_wr) begin
        if (wren) begin
            mem_q[wraddress] <= data;
        end
    end

    always_ff @(posedge clk_rd or posedge reset) begin
        if (reset && RST_Q) begin
            rd_q <= '0;
        end else if (rden) begin
            rd_q <= mem_q[rdaddress];
        end
    end

    if (DO_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] oreg_q;
        always_ff @(posedge clk_rd or posedge reset) begin
            if (reset && RST_Q) begin
                oreg_q <= '0;
            end else begin
                oreg_q <= rd_q;
            end
        end
        assign q = oreg_q;
    end else begin : g_noreg
        assign q = rd_q;
    end

endmodule

// File: rtl/sdpram_fwft_fifo.sv
// First-word-fall-through FIFO over intel_sdpram; a register prefetch
// buffer hides the RAM read latency for a full-rate valid/ready output.
module sdpram_fwft_fifo
    import dma_buf_pkg::*;
#(
    parameter int    ADDR_W     = 9,
    parameter int    DATA_W     = 64,
    parameter int    RAM_DO_REG = 0,
    parameter string BRAM_TYPE  = "M20K",
    parameter int    AFULL_TH   = 2**ADDR_W - 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              afull,
    output logic              overflow,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_rdy,
    output logic [ADDR_W:0]   count
);

    localparam int L    = ram_rd_lat(RAM_DO_REG);
    localparam int PF_D = pf_depth(RAM_DO_REG);
    localparam int CW   = cnt_w(ADDR_W);
    localparam logic [CW-1:0] CAP  = CW'(2**ADDR_W);
    localparam logic [CW-1:0] AFTH = CW'(AFULL_TH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        infl_q, infl_d;
    logic [L-1:0]      vld_sr_q, vld_sr_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;

    logic              push, pop, rden, cap, credit_ok;
    logic [DATA_W-1:0] ram_q;

    always_comb begin
        push      = wr_en && !full_q;
        rden      = (ram_cnt_q != '0) && credit_ok;
        cap       = vld_sr_q[L-1];
        wr_ptr_d  = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d  = rd_ptr_q + ADDR_W'(rden);
        ram_cnt_d = ram_cnt_q + CW'(push) - CW'(rden);
        infl_d    = infl_q + 2'(rden) - 2'(cap);
        // one marker per issued read, aligned with q after L cycles
        vld_sr_d  = (vld_sr_q << 1) | L'(rden);
        count_d   = count_q + CW'(push) - CW'(pop);
        full_d    = (count_d == CAP);
        afull_d   = (count_d >= AFTH);
        ovf_d     = wr_en && full_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            infl_q    <= '0;
            vld_sr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            infl_q    <= infl_d;
            vld_sr_q  <= vld_sr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
        end
    end

    intel_sdpram #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DO_REG   (RAM_DO_REG),
        .BRAM_TYPE(BRAM_TYPE)
    ) u_ram (
        .clk_wr   (clk),
        .clk_rd   (clk),
        .reset    (reset),
        .wren     (push),
        .wraddress(wr_ptr_q),
        .data     (wr_data),
        .rden     (rden),
        .rdaddress(rd_ptr_q),
        .q        (ram_q)
    );

    fwft_prefetch_buf #(
        .DATA_W(DATA_W),
        .PF_D  (PF_D)
    ) u_pf (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (cap),
        .cap_data (ram_q),
        .rd_rdy   (rd_rdy),
        .infl     (infl_q),
        .rd_vld   (rd_vld),
        .rd_data  (rd_data),
        .pop      (pop),
        .credit_ok(credit_ok)
    );

    assign full     = full_q;
    assign afull    = afull_q;
    assign overflow = ovf_q;
    assign count    = count_q;

endmodule
